// File: rtl/sif_xa_arb_if.sv
// Signal bundle between the two host requesters, the arbiter and the sif X access port.
// slave is the arbiter's view; master is the environment (requesters plus sif) view.
interface sif_xa_arb_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;

  logic          xa_wr_s;
  logic          xa_rd_s;
  logic [AW-1:0] xa_addr;
  logic [DW-1:0] xa_data_wr;
  logic [DW-1:0] xa_data_rd;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  xa_data_rd,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output xa_wr_s, xa_rd_s, xa_addr, xa_data_wr
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output xa_data_rd,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  xa_wr_s, xa_rd_s, xa_addr, xa_data_wr
  );
endinterface

// File: rtl/sif_xa_arb.sv
// Two-requester round-robin arbiter for the sif X access port. The winning command is
// registered onto xa_*; a tag pipeline steers each read's data back to its issuer.
module sif_xa_arb #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input logic         clk,
  input logic         rst_b,
  input logic         en,
  sif_xa_arb_if.slave bus
);

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_e;

  prio_e             prio_q, prio_d;
  logic              a_gnt_w, b_gnt_w;
  logic              xfer_w;
  logic              sel_we_w;
  logic              sel_src_w;
  logic [AW-1:0]     sel_addr_w;
  logic [DW-1:0]     sel_wdata_w;

  logic              wr_s_q, rd_s_q;
  logic              cmd_src_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;

  logic [RD_LAT-1:0] tag_vld_q;
  logic [RD_LAT-1:0] tag_src_q;

  // Grant and priority; rst_b is high-true, so a request in a reset cycle is never taken.
  always_comb begin
    a_gnt_w = 1'b0;
    b_gnt_w = 1'b0;
    prio_d  = prio_q;
    if (!rst_b && en) begin
      if (bus.a_req && (!bus.b_req || prio_q == PRIO_A)) begin
        a_gnt_w = 1'b1;
      end else if (bus.b_req) begin
        b_gnt_w = 1'b1;
      end
    end
    if (a_gnt_w) begin
      prio_d = PRIO_B;
    end else if (b_gnt_w) begin
      prio_d = PRIO_A;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      prio_q <= PRIO_A;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign xfer_w      = a_gnt_w | b_gnt_w;
  assign sel_src_w   = b_gnt_w;
  assign sel_we_w    = b_gnt_w ? bus.b_we    : bus.a_we;
  assign sel_addr_w  = b_gnt_w ? bus.b_addr  : bus.a_addr;
  assign sel_wdata_w = b_gnt_w ? bus.b_wdata : bus.a_wdata;

  // Command stage: strobes last one cycle, address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      wr_s_q    <= 1'b0;
      rd_s_q    <= 1'b0;
      cmd_src_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      wr_s_q <= xfer_w & sel_we_w;
      rd_s_q <= xfer_w & ~sel_we_w;
      if (xfer_w) begin
        addr_q    <= sel_addr_w;
        cmd_src_q <= sel_src_w;
      end
      if (xfer_w && sel_we_w) begin
        wdata_q <= sel_wdata_w;
      end
    end
  end

  // Tag stage: entry 0 captures the strobe cycle, the last entry lines up with xa_data_rd.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      tag_vld_q <= '0;
    end else begin
      tag_vld_q[0] <= rd_s_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_src_q[0] <= cmd_src_q;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_src_q[i] <= tag_src_q[i-1];
    end
  end

  assign bus.a_gnt      = a_gnt_w;
  assign bus.b_gnt      = b_gnt_w;
  assign bus.xa_wr_s    = wr_s_q;
  assign bus.xa_rd_s    = rd_s_q;
  assign bus.xa_addr    = addr_q;
  assign bus.xa_data_wr = wdata_q;
  assign bus.a_rvalid   = tag_vld_q[RD_LAT-1] & ~tag_src_q[RD_LAT-1];
  assign bus.b_rvalid   = tag_vld_q[RD_LAT-1] &  tag_src_q[RD_LAT-1];
  assign bus.a_rdata    = bus.xa_data_rd;
  assign bus.b_rdata    = bus.xa_data_rd;

endmodule

// File: tb/tb_sif_xa_arb.sv
// Bench for sif_xa_arb: three instances (RD_LAT 1, 2, 3) share one stimulus stream and are
// compared against a transaction-level model of grants, command strobes and read returns.
`timescale 1ns/1ps
module tb_sif_xa_arb;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_b, en;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;

  always #5 clk = ~clk;

  logic [2:0]    o_agnt, o_bgnt, o_arv, o_brv, o_wr, o_rd;
  logic [AW-1:0] o_addr [3];
  logic [DW-1:0] o_wd [3];
  logic [DW-1:0] o_ard [3];
  logic [DW-1:0] o_brd [3];
  logic [DW-1:0] s_rd [3];

  sif_xa_arb_if #(.AW(AW), .DW(DW)) if1 ();
  sif_xa_arb_if #(.AW(AW), .DW(DW)) if2 ();
  sif_xa_arb_if #(.AW(AW), .DW(DW)) if3 ();

`define TB_TIE(IFN, K) \
  assign IFN.a_req = a_req; assign IFN.a_we = a_we; assign IFN.a_addr = a_addr; assign IFN.a_wdata = a_wdata; \
  assign IFN.b_req = b_req; assign IFN.b_we = b_we; assign IFN.b_addr = b_addr; assign IFN.b_wdata = b_wdata; \
  assign IFN.xa_data_rd = s_rd[K]; \
  assign o_agnt[K] = IFN.a_gnt; assign o_bgnt[K] = IFN.b_gnt; assign o_arv[K] = IFN.a_rvalid; assign o_brv[K] = IFN.b_rvalid; \
  assign o_wr[K] = IFN.xa_wr_s; assign o_rd[K] = IFN.xa_rd_s; assign o_addr[K] = IFN.xa_addr; assign o_wd[K] = IFN.xa_data_wr; \
  assign o_ard[K] = IFN.a_rdata; assign o_brd[K] = IFN.b_rdata;

  `TB_TIE(if1, 0)
  `TB_TIE(if2, 1)
  `TB_TIE(if3, 2)

  sif_xa_arb #(.AW(AW), .DW(DW), .RD_LAT(1)) u_l1 (.clk(clk), .rst_b(rst_b), .en(en), .bus(if1));
  sif_xa_arb #(.AW(AW), .DW(DW), .RD_LAT(2)) u_l2 (.clk(clk), .rst_b(rst_b), .en(en), .bus(if2));
  sif_xa_arb #(.AW(AW), .DW(DW), .RD_LAT(3)) u_l3 (.clk(clk), .rst_b(rst_b), .en(en), .bus(if3));

  // sif storage model per instance: latency k+1 read pipe, random data when no read is due
  logic          mem_clr;
  logic [DW-1:0] smem [3][256];
  logic [DW-1:0] spipe [3][4];
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mem_clr) begin
        for (int m = 0; m < 256; m++) smem[k][m] <= '0;
      end else if (o_wr[k]) begin
        smem[k][o_addr[k][7:0]] <= o_wd[k];
      end
      spipe[k][0] <= o_rd[k] ? smem[k][o_addr[k][7:0]] : DW'($urandom);
      for (int j = 1; j < 4; j++) spipe[k][j] <= spipe[k][j-1];
    end
  end
  assign s_rd[0] = spipe[0][0];
  assign s_rd[1] = spipe[1][1];
  assign s_rd[2] = spipe[2][2];

  // Reference model: who wins, what the sif port shows, and which reads come back when.
  typedef struct {int due; int lat; logic src; logic [DW-1:0] data;} ret_t;
  ret_t          pend[$];
  int            m_prio;
  logic          e_wr, e_rd;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  logic [DW-1:0] mmem [256];

  function automatic logic exp_gnt_a();
    return !rst_b && en && a_req && (!b_req || m_prio == 0);
  endfunction

  function automatic logic exp_gnt_b();
    return !rst_b && en && b_req && (!a_req || m_prio == 1);
  endfunction

  function automatic logic [DW+1:0] exp_ret(int k);
    logic [DW+1:0] r = '0;
    foreach (pend[i]) if (pend[i].lat == k + 1 && pend[i].due == cyc) r = {~pend[i].src, pend[i].src, pend[i].data};
    return r;
  endfunction

  task automatic tick();
    logic ga, gb, we;
    logic [AW-1:0] ad;
    ret_t t;
    ga = exp_gnt_a();
    gb = exp_gnt_b();
    @(posedge clk);
    cyc++;
    if (rst_b) begin
      m_prio = 0; e_wr = 1'b0; e_rd = 1'b0; e_addr = '0; e_wd = '0;
      pend.delete();
    end else if (ga || gb) begin
      we = gb ? b_we : a_we;
      ad = gb ? b_addr : a_addr;
      e_wr = we; e_rd = !we; e_addr = ad;
      if (we) begin
        e_wd = gb ? b_wdata : a_wdata;
        mmem[ad[7:0]] = e_wd;
      end else begin
        for (int l = 1; l <= 3; l++) begin
          t.due = cyc + l; t.lat = l; t.src = gb; t.data = mmem[ad[7:0]];
          pend.push_back(t);
        end
      end
      m_prio = gb ? 0 : 1;
    end else begin
      e_wr = 1'b0; e_rd = 1'b0;
    end
    for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].due < cyc) pend.delete(i);
    @(negedge clk);
  endtask

  task automatic issue(input logic src, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    a_req = !src; b_req = src;
    if (src) begin b_we = we; b_addr = ad; b_wdata = wd; end
    else begin a_we = we; a_addr = ad; a_wdata = wd; end
    #1;
    tick();
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b1; en = 1'b1; a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b1;
    a_addr = 16'h1234; b_addr = 16'h5678; a_wdata = 16'hAAAA; b_wdata = 16'h5555;
    for (int c = 0; c < 2; c++) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        total++;
        if ({o_agnt[k], o_bgnt[k]} !== 2'b00) begin bad++; $display("FAIL reset_gnt[%0d]: got %b want 00", k, {o_agnt[k], o_bgnt[k]}); end
      end
      tick();
      mem_clr = 1'b0;
      for (int k = 0; k < 3; k++) begin
        total++;
        if ({o_wr[k], o_rd[k], o_addr[k], o_wd[k], o_arv[k], o_brv[k]} !== '0)
          begin bad++; $display("FAIL reset_out[%0d]: got wr=%b rd=%b addr=%h wd=%h rv=%b%b want all 0", k, o_wr[k], o_rd[k], o_addr[k], o_wd[k], o_arv[k], o_brv[k]); end
      end
    end
    rst_b = 1'b0; a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_single_write();
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0010; a_wdata = 16'hBEEF;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({o_agnt[k], o_bgnt[k]} !== 2'b10) begin bad++; $display("FAIL wr_gnt[%0d]: got %b want 10", k, {o_agnt[k], o_bgnt[k]}); end
    end
    tick();
    a_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({o_wr[k], o_rd[k], o_addr[k], o_wd[k]} !== {2'b10, 16'h0010, 16'hBEEF})
        begin bad++; $display("FAIL wr_cmd[%0d]: got wr=%b rd=%b addr=%h wd=%h want 1 0 0010 beef", k, o_wr[k], o_rd[k], o_addr[k], o_wd[k]); end
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({o_wr[k], o_rd[k], o_addr[k], o_wd[k]} !== {2'b00, 16'h0010, 16'hBEEF})
        begin bad++; $display("FAIL wr_idle[%0d]: got wr=%b rd=%b addr=%h wd=%h want 0 0 0010 beef", k, o_wr[k], o_rd[k], o_addr[k], o_wd[k]); end
    end
  endtask

  task automatic test_read_return();
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0010;
    #1;
    total++;
    if ({o_agnt[0], o_bgnt[0]} !== 2'b01) begin bad++; $display("FAIL rd_gnt: got %b want 01", {o_agnt[0], o_bgnt[0]}); end
    tick();
    b_req = 1'b0;
    total++;
    if ({o_wr[0], o_rd[0], o_addr[0]} !== {2'b01, 16'h0010}) begin bad++; $display("FAIL rd_strobe: got wr=%b rd=%b addr=%h want 0 1 0010", o_wr[0], o_rd[0], o_addr[0]); end
    tick();
    total++;
    if ({o_arv[0], o_brv[0], o_brd[0]} !== {2'b01, 16'hBEEF})
      begin bad++; $display("FAIL rd_return: got arv=%b brv=%b brd=%h want 0 1 beef", o_arv[0], o_brv[0], o_brd[0]); end
    for (int c = 0; c < 3; c++) tick();
  endtask

  task automatic test_contention();
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        total++;
        if ({o_agnt[k], o_bgnt[k]} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
          begin bad++; $display("FAIL contend_gnt[%0d] step %0d: got %b want %s", k, i, {o_agnt[k], o_bgnt[k]}, (i % 2 == 0) ? "A" : "B"); end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        total++;
        if ({o_wr[k] | o_rd[k], o_wr[k], o_addr[k], o_wd[k]} !== {1'b1, e_wr, e_addr, e_wd})
          begin bad++; $display("FAIL contend_cmd[%0d] step %0d: got wr=%b rd=%b addr=%h wd=%h want wr=%b addr=%h wd=%h", k, i, o_wr[k], o_rd[k], o_addr[k], o_wd[k], e_wr, e_addr, e_wd); end
      end
      if (i % 2 == 0) begin a_we = 1'($urandom); a_addr = AW'($urandom); a_wdata = DW'($urandom); end
      else begin b_we = 1'($urandom); b_addr = AW'($urandom); b_wdata = DW'($urandom); end
    end
    a_req = 1'b0; b_req = 1'b0;
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_interleaved();
    logic [DW+1:0] er;
    logic [DW+1:0] want;
    issue(1'b0, 1'b1, 16'h0001, 16'h1111);
    issue(1'b1, 1'b1, 16'h0002, 16'h2222);
    issue(1'b0, 1'b1, 16'h0003, 16'h3333);
    issue(1'b0, 1'b0, 16'h0001, 16'h0000);
    issue(1'b1, 1'b0, 16'h0002, 16'h0000);
    issue(1'b0, 1'b0, 16'h0003, 16'h0000);
    for (int c = 0; c < 6; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        er = exp_ret(k);
        total++;
        if ({o_arv[k], o_brv[k]} !== er[DW+1:DW]) begin bad++; $display("FAIL ilv_rvalid[%0d] c%0d: got %b%b want %b", k, c, o_arv[k], o_brv[k], er[DW+1:DW]); end
      end
      case (c)
        0: want = {2'b10, 16'h1111};
        1: want = {2'b01, 16'h2222};
        2: want = {2'b10, 16'h3333};
        default: want = '0;
      endcase
      total++;
      if ({o_arv[2], o_brv[2]} !== want[DW+1:DW] || (want[DW+1:DW] != 2'b00 && s_rd[2] !== want[DW-1:0]))
        begin bad++; $display("FAIL ilv_l3 c%0d: got rv=%b%b data=%h want rv=%b data=%h", c, o_arv[2], o_brv[2], s_rd[2], want[DW+1:DW], want[DW-1:0]); end
    end
  endtask

  task automatic test_disrupt();
    logic [DW+1:0] er;
    int            seen [3];
    seen = '{0, 0, 0};
    issue(1'b0, 1'b0, 16'h0001, 16'h0000);
    en = 1'b0; a_req = 1'b1; b_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        total++;
        if ({o_agnt[k], o_bgnt[k]} !== 2'b00) begin bad++; $display("FAIL en0_gnt[%0d]: got %b want 00", k, {o_agnt[k], o_bgnt[k]}); end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        er = exp_ret(k);
        total++;
        if ({o_wr[k], o_rd[k]} !== 2'b00 || {o_arv[k], o_brv[k]} !== er[DW+1:DW] || (o_arv[k] && o_ard[k] !== 16'h1111))
          begin bad++; $display("FAIL en0_drain[%0d] c%0d: got st=%b%b rv=%b%b ard=%h want st=00 rv=%b ard=1111", k, c, o_wr[k], o_rd[k], o_arv[k], o_brv[k], o_ard[k], er[DW+1:DW]); end
        seen[k] += int'(o_arv[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (seen[k] != 1) begin bad++; $display("FAIL en0_count[%0d]: got %0d returns want 1", k, seen[k]); end
    end
    en = 1'b1; a_req = 1'b0; b_req = 1'b0;
    issue(1'b1, 1'b0, 16'h0002, 16'h0000);
    tick();
    total++;
    if ({o_brv[0], o_brd[0]} !== {1'b1, 16'h2222}) begin bad++; $display("FAIL rst_l1_ret: got brv=%b brd=%h want 1 2222", o_brv[0], o_brd[0]); end
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if ({o_arv[1], o_brv[1], o_arv[2], o_brv[2]} !== 4'b0000)
        begin bad++; $display("FAIL rst_discard c%0d: got l2=%b%b l3=%b%b want 0000", c, o_arv[1], o_brv[1], o_arv[2], o_brv[2]); end
      tick();
    end
  endtask

  task automatic test_random();
    logic          ga, gb;
    logic [DW+1:0] er;
    ga = 1'b1; gb = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (!a_req || ga) begin a_req = ($urandom_range(0, 2) != 0); a_we = 1'($urandom); a_addr = AW'($urandom_range(0, 15)); a_wdata = DW'($urandom); end
      if (!b_req || gb) begin b_req = ($urandom_range(0, 2) != 0); b_we = 1'($urandom); b_addr = AW'($urandom_range(0, 15)); b_wdata = DW'($urandom); end
      en    = ($urandom_range(0, 7) != 0);
      rst_b = ($urandom_range(0, 49) == 0);
      #1;
      ga = exp_gnt_a();
      gb = exp_gnt_b();
      for (int k = 0; k < 3; k++) begin
        total++;
        if ({o_agnt[k], o_bgnt[k]} !== {ga, gb}) begin bad++; $display("FAIL rnd_gnt[%0d] n%0d: got %b want %b", k, n, {o_agnt[k], o_bgnt[k]}, {ga, gb}); end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        er = exp_ret(k);
        total++;
        if ({o_wr[k], o_rd[k], o_addr[k], o_wd[k]} !== {e_wr, e_rd, e_addr, e_wd})
          begin bad++; $display("FAIL rnd_cmd[%0d] n%0d: got %b%b %h %h want %b%b %h %h", k, n, o_wr[k], o_rd[k], o_addr[k], o_wd[k], e_wr, e_rd, e_addr, e_wd); end
        total++;
        if ({o_arv[k], o_brv[k]} !== er[DW+1:DW] || (er[DW+1:DW] != 2'b00 && s_rd[k] !== er[DW-1:0]))
          begin bad++; $display("FAIL rnd_ret[%0d] n%0d: got rv=%b%b data=%h want rv=%b data=%h", k, n, o_arv[k], o_brv[k], s_rd[k], er[DW+1:DW], er[DW-1:0]); end
        total++;
        if (o_ard[k] !== s_rd[k] || o_brd[k] !== s_rd[k])
          begin bad++; $display("FAIL rnd_rdata[%0d] n%0d: got a=%h b=%h want %h", k, n, o_ard[k], o_brd[k], s_rd[k]); end
      end
    end
    rst_b = 1'b0; en = 1'b1; a_req = 1'b0; b_req = 1'b0;
    for (int c = 0; c < 4; c++) tick();
  endtask

  initial begin
    mem_clr = 1'b1;
    m_prio = 0; e_wr = 1'b0; e_rd = 1'b0; e_addr = '0; e_wd = '0;
    for (int m = 0; m < 256; m++) mmem[m] = '0;
    test_reset();
    test_single_write();
    test_read_return();
    test_contention();
    test_interleaved();
    test_disrupt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
